// File: rtl/fc_pkg.sv
// Shared definitions for the FC layer sequencer: default layer tables,
// FSM state encoding and the selector code that means "no buffer active".
package fc_pkg;

  localparam int NUM_LAYER_DEF = 5;
  localparam int MAX_LAYER     = 8;

  // Selector default: all buffers idle.
  localparam logic [2:0] IDLE_LAYER = 3'd7;

  // Tables are packed, index 0 in the least-significant slot.
  typedef logic [MAX_LAYER-1:0][14:0] rd_tbl_t;
  typedef logic [MAX_LAYER-1:0][11:0] wr_tbl_t;

  // Chained network: each layer's output count is the next layer's input count.
  localparam rd_tbl_t RD_LEN_TBL_DEF = {15'd1, 15'd1, 15'd1, 15'd32,
                                        15'd64, 15'd128, 15'd256, 15'd784};
  localparam wr_tbl_t WR_LEN_TBL_DEF = {12'd1, 12'd1, 12'd1, 12'd10,
                                        12'd32, 12'd64, 12'd128, 12'd256};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DONE     = 2'd3
  } fc_state_t;

endpackage

// File: rtl/fc_len_lut.sv
// Layer index -> input/output word counts. Zero entries are illegal and
// are read as 1 so the counters always have a reachable terminal value.
module fc_len_lut
  import fc_pkg::*;
#(
  parameter rd_tbl_t RD_LEN_TBL = RD_LEN_TBL_DEF,
  parameter wr_tbl_t WR_LEN_TBL = WR_LEN_TBL_DEF
) (
  input  logic [2:0]  layer_i,
  output logic [14:0] rd_len_o,
  output logic [11:0] wr_len_o
);

  // Table lookup with zero-length entries promoted to one word.
  always_comb begin
    rd_len_o = RD_LEN_TBL[layer_i];
    wr_len_o = WR_LEN_TBL[layer_i];
    if (rd_len_o == 15'd0) rd_len_o = 15'd1;
    if (wr_len_o == 12'd0) wr_len_o = 12'd1;
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequences NUM_LAYER fully-connected layers: for every output word of a
// layer it streams the whole input vector to the compute core, then waits
// for one result word and writes it. Handshake: an input word moves on a
// cycle where rd_bram_en_o=1 (which only happens with ip_ready_i=1 in READ);
// a result word is accepted on a cycle where wr_bram_en_o=1 and
// ip_data_valid_i=1. A result presented outside WAIT_RES is a protocol
// error and sets the sticky err_o.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int      NUM_LAYER  = NUM_LAYER_DEF,
  parameter rd_tbl_t RD_LEN_TBL = RD_LEN_TBL_DEF,
  parameter wr_tbl_t WR_LEN_TBL = WR_LEN_TBL_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ip_ready_i,
  input  logic        ip_data_valid_i,
  output logic [2:0]  cur_layer_index_o,
  output logic        rd_bram_en_o,
  output logic [14:0] rd_bram_addr_o,
  output logic        rd_last_o,
  output logic        wr_bram_en_o,
  output logic [11:0] wr_bram_addr_o,
  output logic        busy_o,
  output logic        layer_done_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  fc_state_t   state_q, state_d;
  logic [2:0]  layer_q, layer_d;
  logic [14:0] rd_cnt_q, rd_cnt_d;
  logic [11:0] wr_cnt_q, wr_cnt_d;
  logic        layer_done_q, layer_done_d;
  logic        err_q;

  logic [14:0] rd_len;
  logic [11:0] wr_len;
  logic        rd_at_last;
  logic        wr_at_last;
  logic        last_layer;

  fc_len_lut #(
    .RD_LEN_TBL (RD_LEN_TBL),
    .WR_LEN_TBL (WR_LEN_TBL)
  ) u_len_lut (
    .layer_i  (layer_q),
    .rd_len_o (rd_len),
    .wr_len_o (wr_len)
  );

  assign rd_at_last = (rd_cnt_q == rd_len - 15'd1);
  assign wr_at_last = (wr_cnt_q == wr_len - 12'd1);
  assign last_layer = (layer_q == 3'(NUM_LAYER - 1));

  // State, counters and pulse registers; reset aborts any pass in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      layer_q      <= 3'd0;
      rd_cnt_q     <= 15'd0;
      wr_cnt_q     <= 12'd0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      layer_done_q <= layer_done_d;
    end
  end

  // Sticky protocol error: a result word offered while none is expected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (ip_data_valid_i && (state_q != ST_WAIT_RES)) begin
      err_q <= 1'b1;
    end
  end

  // Next-state and counter updates. The layer index advances on the same
  // edge that re-enters READ, so the first read of a layer already sees it.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    layer_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_READ;
          layer_d  = 3'd0;
          rd_cnt_d = 15'd0;
          wr_cnt_d = 12'd0;
        end
      end
      ST_READ: begin
        if (ip_ready_i) begin
          if (rd_at_last) begin
            state_d  = ST_WAIT_RES;
            rd_cnt_d = 15'd0;
          end else begin
            rd_cnt_d = rd_cnt_q + 15'd1;
          end
        end
      end
      ST_WAIT_RES: begin
        if (ip_data_valid_i) begin
          if (wr_at_last) begin
            wr_cnt_d     = 12'd0;
            layer_done_d = 1'b1;
            if (last_layer) begin
              state_d = ST_DONE;
            end else begin
              layer_d = layer_q + 3'd1;
              state_d = ST_READ;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + 12'd1;
            state_d  = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and counters; idle states park the selector.
  always_comb begin
    cur_layer_index_o = IDLE_LAYER;
    rd_bram_en_o      = 1'b0;
    rd_bram_addr_o    = 15'd0;
    rd_last_o         = 1'b0;
    wr_bram_en_o      = 1'b0;
    wr_bram_addr_o    = 12'd0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    case (state_q)
      ST_READ: begin
        cur_layer_index_o = layer_q;
        busy_o            = 1'b1;
        rd_bram_en_o      = ip_ready_i;
        rd_bram_addr_o    = rd_cnt_q;
        rd_last_o         = ip_ready_i && rd_at_last;
      end
      ST_WAIT_RES: begin
        cur_layer_index_o = layer_q;
        busy_o            = 1'b1;
        wr_bram_en_o      = 1'b1;
        wr_bram_addr_o    = wr_cnt_q;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign layer_done_o = layer_done_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state_q;

endmodule
